// File: rtl/vend_core_n_if.sv
// Signal bundle between the debounced button/coin layer and the vending core.
// The core takes the slave view; the button layer (or a bench) takes the master view.
interface vend_core_n_if #(
  parameter int N_ITEMS   = 4,
  parameter int STOCK_W   = 4,
  parameter int SELL_W    = 6,
  parameter int TOTAL_W   = 10,
  parameter int MONEY_W   = 6,
  parameter int QTY_MAX   = 3,
  parameter int TIMEOUT_S = 30
);
  localparam int IDW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int QW  = $clog2(QTY_MAX + 1);
  localparam int TW  = $clog2(TIMEOUT_S + 1);

  logic tick, mode, initialize, plus, minus, prev, next;
  logic choiceConfirm, payConfirm, back;
  logic pay1, pay2, pay5, pay10;

  logic [2:0]                 state;
  logic [IDW-1:0]             id;
  logic [QW-1:0]              qty;
  logic [MONEY_W-1:0]         moneyRequired, moneyPaid, change;
  logic [TW-1:0]              timeLeft;
  logic [N_ITEMS*STOCK_W-1:0] stock_flat;
  logic [N_ITEMS*SELL_W-1:0]  sell_flat;
  logic [TOTAL_W-1:0]         total;
  logic                       dispense;
  logic [2:0]                 msg_id;

  modport master (
    output tick, mode, initialize, plus, minus, prev, next,
           choiceConfirm, payConfirm, back, pay1, pay2, pay5, pay10,
    input  state, id, qty, moneyRequired, moneyPaid, change, timeLeft,
           stock_flat, sell_flat, total, dispense, msg_id
  );

  modport slave (
    input  tick, mode, initialize, plus, minus, prev, next,
           choiceConfirm, payConfirm, back, pay1, pay2, pay5, pay10,
    output state, id, qty, moneyRequired, moneyPaid, change, timeLeft,
           stock_flat, sell_flat, total, dispense, msg_id
  );
endinterface

// File: rtl/vend_core_n.sv
// Parametrised vending-machine controller: item selection, quantity, coin
// payment with timeout, change, per-item stock/sales and an admin restock mode.
module vend_core_n #(
  parameter int                         N_ITEMS   = 4,
  parameter int                         PRICE_W   = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES    = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                         STOCK_W   = 4,
  parameter int                         SELL_W    = 6,
  parameter int                         TOTAL_W   = 10,
  parameter int                         MONEY_W   = 6,
  parameter int                         QTY_MAX   = 3,
  parameter int                         TIMEOUT_S = 30
) (
  input logic          rawClk,
  input logic          mSwitch,
  vend_core_n_if.slave bus
);
  localparam int IDW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int QW  = $clog2(QTY_MAX + 1);
  localparam int TW  = $clog2(TIMEOUT_S + 1);

  localparam logic [2:0] MSG_SOLD_OUT = 3'd1;
  localparam logic [2:0] MSG_INSUFF   = 3'd2;
  localparam logic [2:0] MSG_TIMEOUT  = 3'd3;
  localparam logic [2:0] MSG_REJECT   = 3'd4;
  localparam logic [2:0] MSG_SUCCESS  = 3'd5;
  localparam logic [2:0] MSG_LIMIT    = 3'd6;

  typedef enum logic [2:0] {
    ST_OFF = 3'd0, ST_SELECT = 3'd1, ST_QTY = 3'd2,
    ST_PAY = 3'd3, ST_CHANGE = 3'd4, ST_ADMIN = 3'd5
  } state_t;

  state_t               state_r, state_nx;
  logic [IDW-1:0]       id_r, id_nx;
  logic [QW-1:0]        qty_r, qty_nx;
  logic [MONEY_W-1:0]   req_r, req_nx, paid_r, paid_nx, change_r, change_nx;
  logic [TW-1:0]        tl_r, tl_nx;
  logic [STOCK_W-1:0]   stock_r [N_ITEMS];
  logic [STOCK_W-1:0]   stock_nx [N_ITEMS];
  logic [SELL_W-1:0]    sell_r [N_ITEMS];
  logic [SELL_W-1:0]    sell_nx [N_ITEMS];
  logic [TOTAL_W-1:0]   total_r, total_nx;
  logic                 dispense_r, dispense_nx;
  logic [2:0]           msg_r, msg_nx;

  logic [IDW-1:0]       id_inc_s, id_dec_s;
  logic [STOCK_W-1:0]   stock_cur_s, stock_left_s;
  logic [PRICE_W-1:0]   price_s;
  logic [PRICE_W+QW-1:0] prod_s;
  logic [4:0]           coin_s;
  logic [MONEY_W:0]     coin_sum_s;
  logic [SELL_W:0]      sell_sum_s;
  logic [TOTAL_W:0]     total_sum_s;
  int                   qty_cap_s;

  function automatic logic [PRICE_W-1:0] price_of(input logic [IDW-1:0] idx);
    return PRICES[int'(idx)*PRICE_W +: PRICE_W];
  endfunction

  // Shared arithmetic: id wrap, price product, coin choice and saturating sums.
  always_comb begin
    id_inc_s    = (id_r == IDW'(N_ITEMS - 1)) ? IDW'(0) : id_r + IDW'(1);
    id_dec_s    = (id_r == IDW'(0)) ? IDW'(N_ITEMS - 1) : id_r - IDW'(1);
    stock_cur_s = stock_r[id_r];
    qty_cap_s   = (int'(stock_cur_s) < QTY_MAX) ? int'(stock_cur_s) : QTY_MAX;
    price_s     = price_of(id_r);
    prod_s      = {{QW{1'b0}}, price_s} * {{PRICE_W{1'b0}}, qty_r};
    if (int'(stock_cur_s) >= int'(qty_r)) stock_left_s = stock_cur_s - STOCK_W'(qty_r);
    else                                  stock_left_s = {STOCK_W{1'b0}};
    // one coin per cycle, largest denomination wins
    if (bus.pay10)     coin_s = 5'd10;
    else if (bus.pay5) coin_s = 5'd5;
    else if (bus.pay2) coin_s = 5'd2;
    else if (bus.pay1) coin_s = 5'd1;
    else               coin_s = 5'd0;
    coin_sum_s  = {1'b0, paid_r} + (MONEY_W+1)'(coin_s);
    sell_sum_s  = {1'b0, sell_r[id_r]} + (SELL_W+1)'(qty_r);
    total_sum_s = {1'b0, total_r} + (TOTAL_W+1)'(req_r);
  end

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_nx    = state_r;
    id_nx       = id_r;
    qty_nx      = qty_r;
    req_nx      = req_r;
    paid_nx     = paid_r;
    change_nx   = change_r;
    tl_nx       = tl_r;
    stock_nx    = stock_r;
    sell_nx     = sell_r;
    total_nx    = total_r;
    dispense_nx = 1'b0;
    msg_nx      = msg_r;
    case (state_r)
      ST_OFF: state_nx = ST_SELECT;
      ST_SELECT: begin
        if (bus.mode)      state_nx = ST_ADMIN;
        else if (bus.next) id_nx = id_inc_s;
        else if (bus.prev) id_nx = id_dec_s;
        else if (bus.choiceConfirm) begin
          if (stock_cur_s == {STOCK_W{1'b0}}) begin
            msg_nx = MSG_SOLD_OUT;
          end else begin
            qty_nx   = QW'(1);
            state_nx = ST_QTY;
          end
        end else begin
          state_nx = ST_SELECT;
        end
      end
      ST_QTY: begin
        if (bus.back) begin
          state_nx = ST_SELECT;
        end else if (bus.choiceConfirm) begin
          req_nx    = MONEY_W'(prod_s);
          paid_nx   = {MONEY_W{1'b0}};
          change_nx = {MONEY_W{1'b0}};
          tl_nx     = TW'(TIMEOUT_S);
          state_nx  = ST_PAY;
        end else if (bus.plus) begin
          if (int'(qty_r) < qty_cap_s) qty_nx = qty_r + QW'(1);
          else                         msg_nx = MSG_LIMIT;
        end else if (bus.minus) begin
          if (qty_r > QW'(1)) qty_nx = qty_r - QW'(1);
          else                qty_nx = qty_r;
        end else begin
          state_nx = ST_QTY;
        end
      end
      ST_PAY: begin
        if (bus.back) begin
          change_nx = paid_r;
          paid_nx   = {MONEY_W{1'b0}};
          tl_nx     = TW'(0);
          state_nx  = ST_SELECT;
        end else if (bus.payConfirm) begin
          if (paid_r >= req_r) begin
            // sale completes on entry to CHANGE so all results appear together
            change_nx       = paid_r - req_r;
            dispense_nx     = 1'b1;
            msg_nx          = MSG_SUCCESS;
            stock_nx[id_r]  = stock_left_s;
            sell_nx[id_r]   = sell_sum_s[SELL_W] ? {SELL_W{1'b1}} : sell_sum_s[SELL_W-1:0];
            total_nx        = total_sum_s[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum_s[TOTAL_W-1:0];
            tl_nx           = TW'(0);
            state_nx        = ST_CHANGE;
          end else begin
            msg_nx = MSG_INSUFF;
          end
        end else if (bus.tick && tl_r == TW'(1)) begin
          change_nx = paid_r;
          paid_nx   = {MONEY_W{1'b0}};
          tl_nx     = TW'(0);
          msg_nx    = MSG_TIMEOUT;
          state_nx  = ST_SELECT;
        end else begin
          if (bus.tick && tl_r != TW'(0)) tl_nx = tl_r - TW'(1);
          else                            tl_nx = tl_r;
          if (coin_s != 5'd0) begin
            if (coin_sum_s[MONEY_W]) msg_nx = MSG_REJECT;
            else                     paid_nx = coin_sum_s[MONEY_W-1:0];
          end else begin
            paid_nx = paid_r;
          end
        end
      end
      ST_CHANGE: begin
        paid_nx  = {MONEY_W{1'b0}};
        state_nx = ST_SELECT;
      end
      ST_ADMIN: begin
        if (!bus.mode) begin
          state_nx = ST_SELECT;
        end else if (bus.initialize) begin
          for (int i = 0; i < N_ITEMS; i++) stock_nx[i] = {STOCK_W{1'b0}};
        end else if (bus.next) begin
          id_nx = id_inc_s;
        end else if (bus.prev) begin
          id_nx = id_dec_s;
        end else if (bus.plus) begin
          if (stock_cur_s == {STOCK_W{1'b1}}) msg_nx = MSG_LIMIT;
          else                                stock_nx[id_r] = stock_cur_s + STOCK_W'(1);
        end else if (bus.minus) begin
          if (stock_cur_s == {STOCK_W{1'b0}}) msg_nx = MSG_LIMIT;
          else                                stock_nx[id_r] = stock_cur_s - STOCK_W'(1);
        end else begin
          state_nx = ST_ADMIN;
        end
      end
      default: state_nx = ST_OFF;
    endcase
  end

  // State register; mSwitch holds the machine off.
  always_ff @(posedge rawClk) begin
    if (mSwitch) state_r <= ST_OFF;
    else         state_r <= state_nx;
  end

  // Datapath registers: selection, money, timer, counters and messages.
  always_ff @(posedge rawClk) begin
    if (mSwitch) begin
      id_r       <= '0;
      qty_r      <= '0;
      req_r      <= '0;
      paid_r     <= '0;
      change_r   <= '0;
      tl_r       <= '0;
      total_r    <= '0;
      dispense_r <= 1'b0;
      msg_r      <= 3'd0;
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_r[i] <= '0;
        sell_r[i]  <= '0;
      end
    end else begin
      id_r       <= id_nx;
      qty_r      <= qty_nx;
      req_r      <= req_nx;
      paid_r     <= paid_nx;
      change_r   <= change_nx;
      tl_r       <= tl_nx;
      total_r    <= total_nx;
      dispense_r <= dispense_nx;
      msg_r      <= msg_nx;
      stock_r    <= stock_nx;
      sell_r     <= sell_nx;
    end
  end

  // Flatten the per-item counters onto the output buses.
  always_comb begin
    bus.stock_flat = '0;
    bus.sell_flat  = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      bus.stock_flat[i*STOCK_W +: STOCK_W] = stock_r[i];
      bus.sell_flat[i*SELL_W +: SELL_W]    = sell_r[i];
    end
  end

  assign bus.state         = state_r;
  assign bus.id            = id_r;
  assign bus.qty           = qty_r;
  assign bus.moneyRequired = req_r;
  assign bus.moneyPaid     = paid_r;
  assign bus.change        = change_r;
  assign bus.timeLeft      = tl_r;
  assign bus.total         = total_r;
  assign bus.dispense      = dispense_r;
  assign bus.msg_id        = msg_r;
endmodule
